// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and glyph constants for the 7-segment scan controller
package seg_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Segment glyphs, bit order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD nibble to 7-segment glyph decoder
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Non-decimal nibbles render as a dash so corrupt data is visible
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan scheduler with double buffer, PWM and zero blanking
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int SLOT_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [3:0]        BLANK_LEN4 = 4'(BLANK_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

    // Scan sequencing state
    scan_state_e          state_q, state_d;
    logic [SLOT_W-1:0]    slot_q,  slot_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 frame_end;
    logic                 frame_start;

    // Display buffers: shadow is written by load, active is what is shown
    logic [4*NUM_DIGITS-1:0] shadow_q,    shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] active_q,    active_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic                    pending_q,   pending_d;

    // Per-slot datapath
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zeros_above;
    logic [NUM_DIGITS-1:0] slot_onehot;
    logic [3:0]            pwm_phase;
    logic                  drive_on;

    // Registered pin drivers
    logic [6:0]            seg_q,   seg_d;
    logic                  dp_q,    dp_d;
    logic [NUM_DIGITS-1:0] sel_q,   sel_d;
    logic                  fdone_q, fdone_d;

    // FSM and counters; enable low forces IDLE with slot/cnt cleared
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            slot_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    slot_d  = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (slot_q == SLOT_LAST) begin
                            slot_d    = '0;
                            frame_end = 1'b1;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Next cycle is BLANK of slot 0 coming from outside that slot
    assign frame_start = enable && ((state_q == IDLE) || frame_end);

    // Double buffer: transfer uses the pre-edge shadow, so a coincident load stays pending
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pending_d   = pending_q | load;
        if (load) begin
            shadow_d    = digits_in;
            shadow_dp_d = dp_in;
        end
        if (frame_start && pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
            pending_d   = load;
        end
    end

    // Leading-zero mask: digit i blanks when it and every higher digit are zero
    always_comb begin
        zeros_above = 1'b1;
        lz_mask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (active_q[4*i +: 4] == 4'd0);
            lz_mask[i]  = zeros_above && (i != 0);
        end
    end

    // Slot-indexed selection of nibble, dp, blanking and one-hot select
    always_comb begin
        cur_nibble  = 4'd0;
        cur_dp      = 1'b0;
        cur_lz      = 1'b0;
        slot_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_nibble     = active_q[4*i +: 4];
                cur_dp         = active_dp_q[i];
                cur_lz         = lz_mask[i];
                slot_onehot[i] = 1'b1;
            end
        end
    end

    bcd_to_7seg u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (glyph)
    );

    // PWM phase counts from the first drive cycle, modulo 16
    assign pwm_phase = cnt_q[3:0] - BLANK_LEN4;
    assign drive_on  = enable && (state_q == DRIVE) && (pwm_phase <= brightness);

    // Pin values for the next cycle; everything is forced low outside the PWM on-window
    always_comb begin
        seg_d   = '0;
        dp_d    = 1'b0;
        sel_d   = '0;
        fdone_d = frame_end;
        if (drive_on) begin
            sel_d = slot_onehot;
            dp_d  = cur_dp;
            seg_d = (lz_suppress && cur_lz) ? 7'd0 : glyph;
        end
    end

    // Sequencing, buffer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            pending_q   <= 1'b0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            sel_q       <= '0;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
            fdone_q     <= fdone_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] digits_in = '0;
    logic [2:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [2:0]  digit_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (3),
        .SCAN_DIV     (40),
        .BLANK_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load        (load),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .digit_sel   (digit_sel),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] digits;
        logic [2:0]  dp;
        logic        lz;
        logic [3:0]  br;
        logic [20:0] segs;
        logic [2:0]  exp_dp;
        int          hi;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_load(input logic [11:0] d, input logic [2:0] p);
        @(negedge clk);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) chk({name, "_fd_timeout"}, 0, 1);
    endtask

    task automatic wait_sel(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (digit_sel == 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (digit_sel == 3'b000) chk({name, "_sel_timeout"}, 0, 1);
    endtask

    function automatic int sel_idx(input logic [2:0] s);
        case (s)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            3'b000:  return -1;
            default: return -2;
        endcase
    endfunction

    // One full frame after a frame_done sample, checked against vector v
    task automatic measure(input int v);
        int hi[3];
        int bad[3];
        int dpc[3];
        int blank_bad;
        int fdc;
        int ovl;
        int k;
        logic [6:0] es;
        for (int i = 0; i < 3; i++) begin
            hi[i] = 0; bad[i] = 0; dpc[i] = 0;
        end
        blank_bad = 0; fdc = 0; ovl = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            k = sel_idx(digit_sel);
            if (frame_done) fdc++;
            if (k == -2) ovl++;
            else if (k == -1) begin
                if (seg_out != 7'd0 || dp_out) blank_bad++;
            end else begin
                hi[k]++;
                es = vecs[v].segs[7*k +: 7];
                if (seg_out != es) bad[k]++;
                if (dp_out) dpc[k]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("v%0d_hi_d%0d", v, i), hi[i], vecs[v].hi);
            chk($sformatf("v%0d_segbad_d%0d", v, i), bad[i], 0);
            chk($sformatf("v%0d_dp_d%0d", v, i), dpc[i], vecs[v].exp_dp[i] ? vecs[v].hi : 0);
        end
        chk($sformatf("v%0d_blank_leak", v), blank_bad, 0);
        chk($sformatf("v%0d_frame_done", v), fdc, 1);
        chk($sformatf("v%0d_onehot", v), ovl, 0);
    endtask

    initial begin
        int first;
        int cnt_old_bad;
        int cnt_new_good;
        int cnt_new_bad;
        int cnt_old_seen;
        bit seen_fd;
        int k;

        vecs[0] = '{12'h123, 3'b000, 1'b0, 4'd15, {7'h06, 7'h5B, 7'h4F}, 3'b000, 36};
        vecs[1] = '{12'h456, 3'b010, 1'b0, 4'd15, {7'h66, 7'h6D, 7'h7D}, 3'b010, 36};
        vecs[2] = '{12'h007, 3'b000, 1'b1, 4'd15, {7'h00, 7'h00, 7'h07}, 3'b000, 36};
        vecs[3] = '{12'h000, 3'b000, 1'b1, 4'd15, {7'h00, 7'h00, 7'h3F}, 3'b000, 36};
        vecs[4] = '{12'h000, 3'b100, 1'b0, 4'd15, {7'h3F, 7'h3F, 7'h3F}, 3'b100, 36};
        vecs[5] = '{12'h123, 3'b000, 1'b0, 4'd3,  {7'h06, 7'h5B, 7'h4F}, 3'b000, 12};
        vecs[6] = '{12'h123, 3'b000, 1'b0, 4'd0,  {7'h06, 7'h5B, 7'h4F}, 3'b000, 3};
        vecs[7] = '{12'hA0F, 3'b000, 1'b1, 4'd7,  {7'h40, 7'h3F, 7'h40}, 3'b000, 20};
        vecs[8] = '{12'h089, 3'b100, 1'b1, 4'd15, {7'h00, 7'h7F, 7'h6F}, 3'b100, 36};

        // Reset state and idle with enable low
        repeat (3) @(negedge clk);
        chk("rst_seg", int'(seg_out), 0);
        chk("rst_dp", int'(dp_out), 0);
        chk("rst_sel", int'(digit_sel), 0);
        chk("rst_fd", int'(frame_done), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_sel", int'(digit_sel), 0);
        chk("idle_seg", int'(seg_out), 0);

        enable = 1'b1;
        for (int v = 0; v < 9; v++) begin
            lz_suppress = vecs[v].lz;
            brightness  = vecs[v].br;
            do_load(vecs[v].digits, vecs[v].dp);
            wait_fd($sformatf("v%0d_a", v));
            wait_fd($sformatf("v%0d_b", v));
            measure(v);
        end

        // Mid-frame load: current frame keeps old digits, next frame shows new ones
        lz_suppress = 1'b0;
        brightness  = 4'd15;
        do_load(12'h123, 3'b000);
        wait_fd("db_a");
        wait_fd("db_b");
        repeat (50) @(negedge clk);
        do_load(12'h456, 3'b000);
        cnt_old_bad = 0; cnt_new_good = 0; cnt_new_bad = 0; cnt_old_seen = 0;
        seen_fd = 1'b0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            k = sel_idx(digit_sel);
            if (!seen_fd) begin
                if (k == 1) begin
                    cnt_old_seen++;
                    if (seg_out != 7'h5B) cnt_old_bad++;
                end
                if (k == 2 && seg_out != 7'h06) cnt_old_bad++;
            end else if (k == 0) begin
                if (seg_out == 7'h7D) cnt_new_good++;
                else cnt_new_bad++;
            end
            if (frame_done) seen_fd = 1'b1;
        end
        chk("db_old_seen", int'(cnt_old_seen > 0), 1);
        chk("db_old_bad", cnt_old_bad, 0);
        chk("db_new_seen", int'(cnt_new_good > 0), 1);
        chk("db_new_bad", cnt_new_bad, 0);

        // Enable drop mid-DRIVE clears outputs on the next edge; re-enable restarts with blanking
        wait_sel("en_a");
        enable = 1'b0;
        @(negedge clk);
        chk("en_off_sel", int'(digit_sel), 0);
        chk("en_off_seg", int'(seg_out), 0);
        chk("en_off_dp", int'(dp_out), 0);
        chk("en_off_fd", int'(frame_done), 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        first = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (first < 0 && digit_sel != 3'b000) begin
                first = n;
                chk("reen_first_sel", int'(digit_sel), 1);
            end
        end
        chk("reen_latency", first, 5);

        // Asynchronous reset mid-frame clears outputs immediately and empties the active buffer
        wait_sel("ar_a");
        #2 rst_n = 1'b0;
        #1;
        chk("ar_sel", int'(digit_sel), 0);
        chk("ar_seg", int'(seg_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sel("ar_b");
        chk("ar_post_sel", int'(digit_sel), 1);
        chk("ar_post_seg", int'(seg_out), 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
